// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode encodings, enable bit indices, FSM states and decode helpers for alu_op_sequencer
package alu_seq_pkg;
  localparam int OP_W = 4;
  localparam int EN_W = 11;
  localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
  localparam logic [OP_W-1:0] OP_MULT = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD  = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0011;
  localparam logic [OP_W-1:0] OP_DSC  = 4'b1000;
  localparam logic [OP_W-1:0] OP_RSR  = 4'b1001;
  localparam logic [OP_W-1:0] OP_USC  = 4'b1010;
  localparam logic [OP_W-1:0] OP_LSR  = 4'b1011;
  localparam logic [OP_W-1:0] OP_AWC  = 4'b1100;
  localparam logic [OP_W-1:0] OP_AND  = 4'b1101;
  localparam logic [OP_W-1:0] OP_XWC  = 4'b1110;
  localparam logic [OP_W-1:0] OP_OR   = 4'b1111;
  localparam int EN_DSC  = 0;
  localparam int EN_RSR  = 1;
  localparam int EN_USC  = 2;
  localparam int EN_LSR  = 3;
  localparam int EN_AWC  = 4;
  localparam int EN_AND  = 5;
  localparam int EN_XWC  = 6;
  localparam int EN_OR   = 7;
  localparam int EN_MULT = 8;
  localparam int EN_ADD  = 9;
  localparam int EN_SUB  = 10;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RETIRE} state_t;
  // 0100-0111 are the only unassigned encodings
  function automatic logic is_legal(input logic [OP_W-1:0] op);
    return op[3:2] != 2'b01;
  endfunction
  // only mult waits on the datapath handshake
  function automatic logic is_long(input logic [OP_W-1:0] op);
    return op == OP_MULT;
  endfunction
  // nop and illegal opcodes map to an all-zero enable
  function automatic logic [EN_W-1:0] onehot(input logic [OP_W-1:0] op);
    logic [EN_W-1:0] r;
    r = '0;
    case (op)
      OP_DSC:  r[EN_DSC]  = 1'b1;
      OP_RSR:  r[EN_RSR]  = 1'b1;
      OP_USC:  r[EN_USC]  = 1'b1;
      OP_LSR:  r[EN_LSR]  = 1'b1;
      OP_AWC:  r[EN_AWC]  = 1'b1;
      OP_AND:  r[EN_AND]  = 1'b1;
      OP_XWC:  r[EN_XWC]  = 1'b1;
      OP_OR:   r[EN_OR]   = 1'b1;
      OP_MULT: r[EN_MULT] = 1'b1;
      OP_ADD:  r[EN_ADD]  = 1'b1;
      OP_SUB:  r[EN_SUB]  = 1'b1;
      default: r = '0;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/alu_seq_fifo.sv
// alu_seq_fifo: DEPTH x W opcode FIFO with full/empty flags derived from a registered count
module alu_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;
  assign full   = r_cnt == (AW+1)'(DEPTH);
  assign empty  = r_cnt == '0;
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign dout   = r_mem[r_rd];
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      r_wr  <= r_wr + AW'(w_push);
      r_rd  <= r_rd + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  // storage needs no reset; empty flag guards stale entries
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: buffers opcodes and issues them to the ALU datapath one at a time; ALU_SEQ_PERF_CNT_EN adds perf counters
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SHORT_LAT = 1,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [OP_W-1:0] in_opcode,
  output logic            in_ready,
  output logic [EN_W-1:0] op_en,
  output logic            op_start,
  input  logic            dp_done,
  output logic            busy,
  output logic            retire_valid,
  output logic [OP_W-1:0] retire_opcode,
  output logic            err_illegal,
`ifdef ALU_SEQ_PERF_CNT_EN
  output logic [15:0]     perf_retired,
  output logic [15:0]     perf_mult_cycles,
`endif
  output logic            err_timeout
);
  localparam int CW = $clog2(TIMEOUT + SHORT_LAT + 1);
  state_t          r_state;
  state_t          w_next;
  logic [OP_W-1:0] r_op;
  logic [CW-1:0]   r_cnt;
  logic            r_ill;
  logic            r_tmo;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [OP_W-1:0] w_head;
  logic            w_dp;
  logic            w_exec_done;
  assign in_ready = ~rst & ~w_full;
  assign w_push   = in_valid & in_ready;
  assign w_pop    = (r_state == S_IDLE) & ~w_empty;
  // dp_done only counts for mult and never in the op_start cycle
  assign w_dp        = is_long(r_op) & dp_done & (r_cnt != '0);
  assign w_exec_done = is_long(r_op) ? (w_dp | (r_cnt == CW'(TIMEOUT-1))) : (r_cnt == CW'(SHORT_LAT-1));
  alu_seq_fifo #(.DEPTH(DEPTH), .W(OP_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(w_push),
    .pop(w_pop),
    .din(in_opcode),
    .dout(w_head),
    .full(w_full),
    .empty(w_empty)
  );
  // next state and state-decoded outputs
  always_comb begin
    w_next        = r_state;
    op_en         = '0;
    op_start      = 1'b0;
    retire_valid  = 1'b0;
    retire_opcode = '0;
    err_illegal   = 1'b0;
    err_timeout   = 1'b0;
    w_next = (r_state == S_IDLE) ? (w_empty ? S_IDLE : (is_legal(w_head) && w_head != OP_NOP) ? S_EXEC : S_RETIRE)
           : (r_state == S_EXEC) ? (w_exec_done ? S_RETIRE : S_EXEC)
           : S_IDLE;
    op_en         = (r_state == S_EXEC) ? onehot(r_op) : '0;
    op_start      = (r_state == S_EXEC) && (r_cnt == '0);
    retire_valid  = r_state == S_RETIRE;
    retire_opcode = retire_valid ? r_op : '0;
    err_illegal   = retire_valid & r_ill;
    err_timeout   = retire_valid & r_tmo;
  end
  assign busy = (r_state != S_IDLE) | ~w_empty;
  // state register, captured opcode, exec cycle counter and error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_cnt   <= '0;
      r_ill   <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_pop) begin
        r_op  <= w_head;
        r_ill <= ~is_legal(w_head);
        r_tmo <= 1'b0;
        r_cnt <= '0;
      end
      if (r_state == S_EXEC) begin
        r_cnt <= r_cnt + 1'b1;
        r_tmo <= w_exec_done & is_long(r_op) & ~w_dp;
      end
    end
  end
`ifdef ALU_SEQ_PERF_CNT_EN
  logic [15:0] r_perf_ret;
  logic [15:0] r_perf_mul;
  // free-running wrapping counters of retirements and mult exec cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_ret <= '0;
      r_perf_mul <= '0;
    end else begin
      r_perf_ret <= r_perf_ret + 16'(retire_valid);
      r_perf_mul <= r_perf_mul + 16'((r_state == S_EXEC) && is_long(r_op));
    end
  end
  assign perf_retired     = r_perf_ret;
  assign perf_mult_cycles = r_perf_mul;
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed tests with a trace-based reference model of the op sequencer
module tb_alu_op_sequencer;
  localparam int DEPTH = 4;
  localparam int SL = 1;
  localparam int TO = 8;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  in_opcode = 4'd0;
  logic        dp_done = 1'b0;
  logic        in_ready;
  logic [10:0] op_en;
  logic        op_start;
  logic        busy;
  logic        retire_valid;
  logic [3:0]  retire_opcode;
  logic        err_illegal;
  logic        err_timeout;
`ifdef ALU_SEQ_PERF_CNT_EN
  logic [15:0] perf_retired;
  logic [15:0] perf_mult_cycles;
`endif
  int checks = 0;
  int errors = 0;
  int mult_delay = 0;
  typedef struct packed {
    logic [10:0] en;
    logic        st;
    logic        rv;
    logic [3:0]  ro;
    logic        il;
    logic        to;
  } exp_t;
  exp_t       trace[$];
  logic [3:0] q[$];
  int en_idx [16] = '{-1, 8, 9, 10, -1, -1, -1, -1, 0, 1, 2, 3, 4, 5, 6, 7};

  alu_op_sequencer #(.DEPTH(DEPTH), .SHORT_LAT(SL), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_opcode(in_opcode),
    .in_ready(in_ready),
    .op_en(op_en),
    .op_start(op_start),
    .dp_done(dp_done),
    .busy(busy),
    .retire_valid(retire_valid),
    .retire_opcode(retire_opcode),
    .err_illegal(err_illegal),
`ifdef ALU_SEQ_PERF_CNT_EN
    .perf_retired(perf_retired),
    .perf_mult_cycles(perf_mult_cycles),
`endif
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // expected per-cycle outputs for one op from the cycle after it is popped until it retires
  function automatic void build(input logic [3:0] op);
    exp_t e;
    int   n;
    bit   legal;
    legal = !(op inside {4'd4, 4'd5, 4'd6, 4'd7});
    n = (!legal || op == 4'd0) ? 0 : (op == 4'd1) ? ((mult_delay != 0) ? mult_delay + 1 : TO) : SL;
    for (int i = 0; i < n; i++) begin
      e = '0;
      e.en = 11'(1) << en_idx[op];
      e.st = (i == 0);
      trace.push_back(e);
    end
    e = '0;
    e.rv = 1'b1;
    e.ro = op;
    e.il = !legal;
    e.to = (op == 4'd1) && (mult_delay == 0);
    trace.push_back(e);
  endfunction

  always @(posedge clk) begin
    bit do_pop;
    bit full;
    if (rst) begin
      trace.delete();
      q.delete();
    end else begin
      do_pop = (trace.size() == 0) && (q.size() > 0);
      full = q.size() == DEPTH;
      if (trace.size() > 0) void'(trace.pop_front());
      if (do_pop) build(q.pop_front());
      if (in_valid && !full) q.push_back(in_opcode);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    bit   eb;
    bit   er;
    e = '0;
    if (!rst && trace.size() > 0) e = trace[0];
    eb = !rst && (trace.size() > 0 || q.size() > 0);
    er = !rst && (q.size() < DEPTH);
    chk("op_en", 16'(op_en), 16'(e.en));
    chk("op_start", 16'(op_start), 16'(e.st));
    chk("retire_valid", 16'(retire_valid), 16'(e.rv));
    chk("retire_opcode", 16'(retire_opcode), 16'(e.ro));
    chk("err_illegal", 16'(err_illegal), 16'(e.il));
    chk("err_timeout", 16'(err_timeout), 16'(e.to));
    chk("busy", 16'(busy), 16'(eb));
    chk("in_ready", 16'(in_ready), 16'(er));
  end

  initial begin
    forever begin
      @(negedge clk);
      if (op_start && op_en[8] && mult_delay != 0) begin
        repeat (mult_delay) @(posedge clk);
        #1 dp_done = 1'b1;
        @(posedge clk);
        #1 dp_done = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op);
    in_valid = 1'b1;
    in_opcode = op;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_start(input string nm);
    int n;
    n = 0;
    while (!op_start && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_start_seen"}, 16'(op_start), 16'd1);
  endtask

  task automatic count_exec(input string nm, output int n);
    n = 0;
    while (op_en != 11'd0 && n < 50) begin
      n++;
      tick();
    end
    chk({nm, "_len"}, 16'(n), 16'(nm == "mult5" ? 6 : TO));
  endtask

  initial begin
    int n;
    int t0;
    int t1;
    int acc;
    int idx;
    int r;
    logic [3:0] ops [5];
    logic [3:0] want [5];
    logic [3:0] got[$];
    ops = '{4'd2, 4'd3, 4'd8, 4'd9, 4'd10};
    want = '{4'd1, 4'd2, 4'd3, 4'd8, 4'd9};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 16'(in_ready), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 16'(in_ready), 16'd1);
    tick();
    push(4'b0010);
    tick();
    chk("add_start", 16'(op_start), 16'd1);
    chk("add_en", 16'(op_en), 16'h200);
    tick();
    chk("add_retire", 16'(retire_valid), 16'd1);
    chk("add_ret_op", 16'(retire_opcode), 16'd2);
    chk("add_ret_en", 16'(op_en), 16'd0);
    tick();
    mult_delay = 5;
    push(4'b0001);
    wait_start("mult5");
    count_exec("mult5", n);
    chk("mult5_retire", 16'(retire_valid), 16'd1);
    chk("mult5_tmo", 16'(err_timeout), 16'd0);
    tick();
    mult_delay = 0;
    push(4'b0001);
    wait_start("multto");
    count_exec("multto", n);
    chk("multto_retire", 16'(retire_valid), 16'd1);
    chk("multto_tmo", 16'(err_timeout), 16'd1);
    chk("multto_op", 16'(retire_opcode), 16'd1);
    tick();
    in_valid = 1'b1;
    in_opcode = 4'b0000;
    tick();
    in_opcode = 4'b0101;
    tick();
    in_valid = 1'b0;
    t0 = -1;
    t1 = -1;
    for (int i = 0; i < 8; i++) begin
      chk("nopill_en", 16'(op_en), 16'd0);
      if (retire_valid) begin
        if (retire_opcode == 4'b0000) begin
          t0 = i;
          chk("nop_illegal", 16'(err_illegal), 16'd0);
        end else begin
          t1 = i;
          chk("ill_illegal", 16'(err_illegal), 16'd1);
        end
      end
      tick();
    end
    chk("nopill_gap", 16'(t1 - t0), 16'd2);
    chk("nopill_t0", 16'(t0), 16'd0);
    mult_delay = 0;
    push(4'b0001);
    wait_start("fill");
    acc = 0;
    idx = 0;
    in_valid = 1'b1;
    in_opcode = ops[0];
    repeat (6) begin
      if (in_ready) begin
        acc++;
        if (idx < 4) idx++;
      end
      tick();
      in_opcode = ops[idx];
    end
    chk("fill_accepted", 16'(acc), 16'd4);
    chk("fill_ready", 16'(in_ready), 16'd0);
    in_valid = 1'b0;
    n = 0;
    while (got.size() < 5 && n < 80) begin
      if (retire_valid) got.push_back(retire_opcode);
      tick();
      n++;
    end
    chk("fill_count", 16'(got.size()), 16'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) chk($sformatf("fill_order%0d", i), 16'(got[i]), 16'(want[i]));
    end
    tick();
    mult_delay = 0;
    push(4'b0001);
    push(4'b0011);
    tick();
    tick();
    chk("rst_mid_exec", 16'(op_en), 16'h100);
    #2 rst = 1'b1;
    #1;
    chk("arst_en", 16'(op_en), 16'd0);
    chk("arst_busy", 16'(busy), 16'd0);
    chk("arst_retire", 16'(retire_valid), 16'd0);
    chk("arst_ready", 16'(in_ready), 16'd0);
    tick();
    rst = 1'b0;
    r = 0;
    repeat (15) begin
      r += int'(retire_valid);
      tick();
    end
    chk("post_rst_no_retire", 16'(r), 16'd0);
    chk("post_rst_empty", 16'(busy), 16'd0);
    chk("post_rst_ready", 16'(in_ready), 16'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
